// File: rtl/wb_axi_writer.sv
// wb_axi_writer
//   Drains the write-back buffer one entry at a time. Each popped entry
//   becomes a single-beat AXI4-Lite write: AW and W are issued together and
//   complete independently, then B is awaited before the next pop. Busy and
//   error status are exported so the cache controller can fence or flush.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   wb_valid_i/addr_i/data_i entry offered by the write-back buffer
//   wb_ready_o               pop request back to the buffer (IDLE only)
//   aw*/w*/b*                AXI4-Lite write channels (single outstanding)
//   busy_o                   high whenever a write is in flight
//   err_o                    one-cycle pulse after a SLVERR/DECERR response
//   err_addr_o               address of the most recent errored write
//
// Both parameters default to the cache-wide address/data widths (32).
// DATA_WIDTH must be a multiple of 8.
module wb_axi_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    wb_valid_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  output logic                    wb_ready_o,
  output logic                    awvalid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  input  logic                    awready_i,
  output logic                    wvalid_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  input  logic                    wready_i,
  input  logic                    bvalid_i,
  input  logic [1:0]              bresp_i,
  output logic                    bready_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o
);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t state, state_nxt;

  // A channel counts as done if it already handshook earlier or does so now.
  logic aw_done, w_done, accept;
  assign aw_done = !awvalid_o || awready_i;
  assign w_done  = !wvalid_o  || wready_i;
  assign accept  = (state == IDLE) && wb_valid_i;

  // Constant AXI sideband: unprivileged secure data access, full-word strobe.
  assign awprot_o = 3'b000;
  assign wstrb_o  = '1;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (wb_valid_i)        state_nxt = SEND;
      SEND:    if (aw_done && w_done) state_nxt = RESP;
      RESP:    if (bvalid_i)          state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Unregistered outputs decode straight from the state
  always_comb begin
    wb_ready_o = (state == IDLE);
    busy_o     = (state != IDLE);
  end

  // Registered AXI outputs and error status
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      awvalid_o  <= 1'b0;
      wvalid_o   <= 1'b0;
      bready_o   <= 1'b0;
      err_o      <= 1'b0;
      awaddr_o   <= '0;
      wdata_o    <= '0;
      err_addr_o <= '0;
    end else begin
      err_o <= 1'b0;
      if (accept) begin
        awaddr_o  <= wb_addr_i;
        wdata_o   <= wb_data_i;
        awvalid_o <= 1'b1;
        wvalid_o  <= 1'b1;
      end
      if (state == SEND) begin
        if (awready_i) awvalid_o <= 1'b0;
        if (wready_i)  wvalid_o  <= 1'b0;
        if (aw_done && w_done) bready_o <= 1'b1;
      end
      // B is only ever taken in RESP, so an early bvalid_i is simply ignored.
      if (state == RESP && bvalid_i) begin
        bready_o <= 1'b0;
        if (bresp_i[1]) begin
          err_o      <= 1'b1;
          err_addr_o <= awaddr_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_axi_writer.sv
module tb_wb_axi_writer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wb_valid_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ready_o;
  logic        awvalid_o;
  logic [31:0] awaddr_o;
  logic [2:0]  awprot_o;
  logic        awready_i;
  logic        wvalid_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wready_i;
  logic        bvalid_i;
  logic [1:0]  bresp_i;
  logic        bready_o;
  logic        busy_o;
  logic        err_o;
  logic [31:0] err_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_axi_writer dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_ready_o(wb_ready_o),
    .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
    .awready_i(awready_i),
    .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
    .busy_o(busy_o), .err_o(err_o), .err_addr_o(err_addr_o)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
    awready_i = 1; wready_i = 1; bvalid_i = 1; bresp_i = 2'b00;
    tick(); tick();
    total++; if ({wb_ready_o, busy_o} !== 2'b10) begin bad++; $display("FAIL reset ready/busy got=%b exp=10", {wb_ready_o, busy_o}); end
    total++; if ({awvalid_o, wvalid_o, bready_o, err_o} !== 4'b0000) begin bad++; $display("FAIL reset valids got=%b exp=0000", {awvalid_o, wvalid_o, bready_o, err_o}); end
    total++; if ({awaddr_o, wdata_o, err_addr_o} !== 96'd0) begin bad++; $display("FAIL reset regs aw=%h w=%h ea=%h exp=0", awaddr_o, wdata_o, err_addr_o); end
    total++; if ({awprot_o, wstrb_o} !== 7'b000_1111) begin bad++; $display("FAIL reset prot/strb got=%b exp=0001111", {awprot_o, wstrb_o}); end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wb_valid_i = 1; wb_addr_i = 32'h0C; wb_data_i = 32'h1;
    total++; if (wb_ready_o !== 1'b1) begin bad++; $display("FAIL single c0 wb_ready got=%b exp=1", wb_ready_o); end
    tick();                                   // edge 0: accept
    wb_valid_i = 0; wb_addr_i = 32'hDEAD; wb_data_i = 32'hBEEF;
    total++; if ({awvalid_o, wvalid_o, bready_o, wb_ready_o, busy_o} !== 5'b11001) begin bad++; $display("FAIL single c1 flags got=%b exp=11001", {awvalid_o, wvalid_o, bready_o, wb_ready_o, busy_o}); end
    total++; if (awaddr_o !== 32'h0C || wdata_o !== 32'h1) begin bad++; $display("FAIL single c1 addr/data got=%h/%h exp=c/1", awaddr_o, wdata_o); end
    total++; if (wstrb_o !== 4'hF) begin bad++; $display("FAIL single wstrb got=%h exp=f", wstrb_o); end
    tick();                                   // edge 1: AW/W handshake
    total++; if ({awvalid_o, wvalid_o, bready_o, wb_ready_o} !== 4'b0010) begin bad++; $display("FAIL single c2 flags got=%b exp=0010", {awvalid_o, wvalid_o, bready_o, wb_ready_o}); end
    tick();                                   // edge 2: B handshake
    total++; if ({bready_o, wb_ready_o, busy_o, err_o} !== 4'b0100) begin bad++; $display("FAIL single c3 flags got=%b exp=0100", {bready_o, wb_ready_o, busy_o, err_o}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wb_valid_i = 1; wb_addr_i = 32'h0C + i; wb_data_i = 32'd1 + i;
      total++; if (wb_ready_o !== 1'b1) begin bad++; $display("FAIL b2b idle%0d wb_ready got=%b exp=1", i, wb_ready_o); end
      tick();
      wb_addr_i = 32'hFFFF_0000; wb_data_i = 32'hFFFF_FFFF;  // ignored while busy
      total++; if (awvalid_o !== 1'b1 || awaddr_o !== 32'h0C + i || wdata_o !== 32'd1 + i) begin bad++; $display("FAIL b2b aw%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, awvalid_o, awaddr_o, wdata_o, 32'h0C + i, 32'd1 + i); end
      tick();
      total++; if (bready_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL b2b b%0d got bready=%b busy=%b exp 1/1", i, bready_o, busy_o); end
      if (i == 3) wb_valid_i = 0;
      tick();
    end
    total++; if (busy_o !== 1'b0 || awaddr_o !== 32'h0F) begin bad++; $display("FAIL b2b end got busy=%b a=%h exp 0/f", busy_o, awaddr_o); end
    tick();
    total++; if (busy_o !== 1'b0 || awvalid_o !== 1'b0) begin bad++; $display("FAIL b2b idle got busy=%b awvalid=%b exp 0/0", busy_o, awvalid_o); end
  endtask

  // delay_w=1: W stalls 4 cycles with AW immediate; delay_w=0: the mirror.
  task automatic test_skew(input bit delay_w);
    string nm;
    nm = delay_w ? "skew_w" : "skew_aw";
    awready_i = delay_w; wready_i = !delay_w; bvalid_i = 1;
    wb_valid_i = 1; wb_addr_i = 32'h20; wb_data_i = 32'hA5A5_0001;
    tick();
    wb_valid_i = 0;
    for (int k = 1; k <= 5; k++) begin
      if (delay_w) begin
        total++; if (wvalid_o !== 1'b1 || wdata_o !== 32'hA5A5_0001 || awvalid_o !== (k == 1)) begin bad++; $display("FAIL %s c%0d got w=%b d=%h aw=%b", nm, k, wvalid_o, wdata_o, awvalid_o); end
      end else begin
        total++; if (awvalid_o !== 1'b1 || awaddr_o !== 32'h20 || wvalid_o !== (k == 1)) begin bad++; $display("FAIL %s c%0d got aw=%b a=%h w=%b", nm, k, awvalid_o, awaddr_o, wvalid_o); end
      end
      total++; if (bready_o !== 1'b0) begin bad++; $display("FAIL %s c%0d early bready got=%b exp=0", nm, k, bready_o); end
      if (k == 5) begin awready_i = 1; wready_i = 1; end
      tick();
    end
    total++; if ({awvalid_o, wvalid_o, bready_o} !== 3'b001) begin bad++; $display("FAIL %s c6 got=%b exp=001", nm, {awvalid_o, wvalid_o, bready_o}); end
    tick();
    total++; if (wb_ready_o !== 1'b1) begin bad++; $display("FAIL %s c7 wb_ready got=%b exp=1", nm, wb_ready_o); end
  endtask

  task automatic test_b_backpressure();
    awready_i = 0; wready_i = 1; bvalid_i = 1;
    wb_valid_i = 1; wb_addr_i = 32'h30; wb_data_i = 32'h3;
    tick();
    wb_addr_i = 32'h34; wb_data_i = 32'h4;    // stays offered, must not be popped
    for (int k = 1; k <= 3; k++) begin
      total++; if (bready_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL bearly c%0d got bready=%b busy=%b exp 0/1", k, bready_o, busy_o); end
      if (k == 3) awready_i = 1;
      tick();
    end
    bvalid_i = 0;
    for (int k = 0; k < 6; k++) begin
      total++; if (bready_o !== 1'b1 || wb_ready_o !== 1'b0) begin bad++; $display("FAIL bstall c%0d got bready=%b wb_ready=%b exp 1/0", k, bready_o, wb_ready_o); end
      tick();
    end
    bvalid_i = 1; wb_valid_i = 0;
    tick();
    total++; if (bready_o !== 1'b0 || wb_ready_o !== 1'b1 || awaddr_o !== 32'h30) begin bad++; $display("FAIL bstall end got bready=%b wb_ready=%b a=%h exp 0/1/30", bready_o, wb_ready_o, awaddr_o); end
  endtask

  task automatic test_error();
    wb_valid_i = 1; wb_addr_i = 32'h10; wb_data_i = 32'h55; bresp_i = 2'b10;
    tick(); wb_valid_i = 0;
    tick();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err early pulse got=%b exp=0", err_o); end
    tick();
    total++; if (err_o !== 1'b1 || err_addr_o !== 32'h10) begin bad++; $display("FAIL err pulse got err=%b ea=%h exp 1/10", err_o, err_addr_o); end
    bresp_i = 2'b00;
    wb_valid_i = 1; wb_addr_i = 32'h14; wb_data_i = 32'h66;
    tick(); wb_valid_i = 0;
    total++; if (err_o !== 1'b0 || err_addr_o !== 32'h10) begin bad++; $display("FAIL err width got err=%b ea=%h exp 0/10", err_o, err_addr_o); end
    tick(); tick();
    total++; if (err_o !== 1'b0 || err_addr_o !== 32'h10 || wb_ready_o !== 1'b1) begin bad++; $display("FAIL err okay got err=%b ea=%h rdy=%b exp 0/10/1", err_o, err_addr_o, wb_ready_o); end
    bresp_i = 2'b11;                          // DECERR also counts as an error
    wb_valid_i = 1; wb_addr_i = 32'h18;
    tick(); wb_valid_i = 0; bresp_i = 2'b00;
    tick(); bresp_i = 2'b11;
    tick(); bresp_i = 2'b00;
    total++; if (err_o !== 1'b1 || err_addr_o !== 32'h18) begin bad++; $display("FAIL err decerr got err=%b ea=%h exp 1/18", err_o, err_addr_o); end
  endtask

  task automatic test_reset_mid();
    awready_i = 1; wready_i = 0; bvalid_i = 1;
    wb_valid_i = 1; wb_addr_i = 32'h40; wb_data_i = 32'h77;
    tick(); wb_valid_i = 0;
    tick();
    total++; if (wvalid_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL rmid pre got w=%b busy=%b exp 1/1", wvalid_o, busy_o); end
    #2 rstn_i = 1'b0;
    #1;
    total++; if ({awvalid_o, wvalid_o, bready_o, err_o, busy_o, wb_ready_o} !== 6'b000001) begin bad++; $display("FAIL rmid flags got=%b exp=000001", {awvalid_o, wvalid_o, bready_o, err_o, busy_o, wb_ready_o}); end
    total++; if ({awaddr_o, wdata_o, err_addr_o} !== 96'd0) begin bad++; $display("FAIL rmid regs aw=%h w=%h ea=%h exp 0", awaddr_o, wdata_o, err_addr_o); end
    tick();
    rstn_i = 1'b1; wready_i = 1;
    tick();
    wb_valid_i = 1; wb_addr_i = 32'h44; wb_data_i = 32'h88;
    tick(); wb_valid_i = 0;
    total++; if (awvalid_o !== 1'b1 || wvalid_o !== 1'b1 || awaddr_o !== 32'h44 || wdata_o !== 32'h88) begin bad++; $display("FAIL rmid after got aw=%b w=%b a=%h d=%h exp 1/1/44/88", awvalid_o, wvalid_o, awaddr_o, wdata_o); end
    tick(); tick();
    total++; if (wb_ready_o !== 1'b1 || bready_o !== 1'b0) begin bad++; $display("FAIL rmid done got rdy=%b bready=%b exp 1/0", wb_ready_o, bready_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skew(1'b1);
    test_skew(1'b0);
    test_b_backpressure();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
